// File: rtl/cordic_iter_engine_if.sv
// Operand/result handshake bundle for the iterative CORDIC engine.
// The engine takes the slave side; the sample front-end / consumer take the master side.
interface cordic_iter_engine_if #(
    parameter int WIDTH   = 22,
    parameter int ANGLE_W = 22
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      mode;
    logic signed [WIDTH-1:0]   x_in;
    logic signed [WIDTH-1:0]   y_in;
    logic signed [ANGLE_W-1:0] z_in;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [WIDTH-1:0]   x_out;
    logic signed [WIDTH-1:0]   y_out;
    logic signed [ANGLE_W-1:0] z_out;

    modport master (
        output in_valid, mode, x_in, y_in, z_in, out_ready,
        input  in_ready, out_valid, x_out, y_out, z_out
    );

    modport slave (
        input  in_valid, mode, x_in, y_in, z_in, out_ready,
        output in_ready, out_valid, x_out, y_out, z_out
    );
endinterface

// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC: ITER micro-rotations on one shared x/y/z datapath,
// rotation (z -> 0) or vectoring (y -> 0) mode, no gain compensation.
module cordic_iter_engine #(
    parameter int WIDTH   = 22,
    parameter int ANGLE_W = 22,
    parameter int ITER    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cordic_iter_engine_if.slave  io
);
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // atan(2^-i) scaled so that 2^(ANGLE_W-1) represents pi, rounded to nearest.
    function automatic logic signed [ANGLE_W-1:0] atan_entry(input int i);
        real pi_r;
        real ang;
        pi_r = 4.0 * $atan(1.0);
        ang  = $atan(1.0 / (2.0 ** i)) * (2.0 ** (ANGLE_W - 1)) / pi_r;
        return ANGLE_W'($rtoi(ang + 0.5));
    endfunction

    logic signed [ANGLE_W-1:0] atan_tab [ITER];

    for (genvar g = 0; g < ITER; g++) begin : g_atan
        assign atan_tab[g] = atan_entry(g);
    end

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic                      mode_r;
    logic signed [WIDTH-1:0]   x_r, y_r;
    logic signed [ANGLE_W-1:0] z_r;
    logic signed [WIDTH-1:0]   x_out_r, y_out_r;
    logic signed [ANGLE_W-1:0] z_out_r;

    logic                      last_iter;
    logic                      sigma_pos;
    logic signed [WIDTH-1:0]   x_sh, y_sh, x_nxt, y_nxt;
    logic signed [ANGLE_W-1:0] z_nxt;

    assign last_iter = (cnt == CNT_W'(ITER - 1));

    // Direction: rotation steers z toward 0, vectoring steers y toward 0.
    always_comb begin
        sigma_pos = mode_r ? y_r[WIDTH-1] : ~z_r[ANGLE_W-1];
        x_sh      = x_r >>> cnt;
        y_sh      = y_r >>> cnt;
        if (sigma_pos) begin
            x_nxt = x_r - y_sh;
            y_nxt = y_r + x_sh;
            z_nxt = z_r - atan_tab[cnt];
        end else begin
            x_nxt = x_r + y_sh;
            y_nxt = y_r - x_sh;
            z_nxt = z_r + atan_tab[cnt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (io.in_valid)  state_nxt = RUN;
            RUN:     if (last_iter)    state_nxt = DONE;
            DONE:    if (io.out_ready) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            mode_r  <= 1'b0;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            x_out_r <= '0;
            y_out_r <= '0;
            z_out_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        cnt    <= '0;
                        mode_r <= io.mode;
                        x_r    <= io.x_in;
                        y_r    <= io.y_in;
                        z_r    <= io.z_in;
                    end
                end
                RUN: begin
                    x_r <= x_nxt;
                    y_r <= y_nxt;
                    z_r <= z_nxt;
                    cnt <= cnt + 1'b1;
                    // Result registers load only on the final micro-rotation and then hold.
                    if (last_iter) begin
                        x_out_r <= x_nxt;
                        y_out_r <= y_nxt;
                        z_out_r <= z_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.x_out     = x_out_r;
    assign io.y_out     = y_out_r;
    assign io.z_out     = z_out_r;
endmodule

// File: tb/tb_cordic_iter_engine.sv
// Directed bench for cordic_iter_engine: default 22/22/16 instance plus a 16/16/12 instance.
module tb_cordic_iter_engine;
    localparam int W1 = 22, A1 = 22, I1 = 16;
    localparam int W2 = 16, A2 = 16, I2 = 12;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    cordic_iter_engine_if #(.WIDTH(W1), .ANGLE_W(A1)) if0 ();
    cordic_iter_engine_if #(.WIDTH(W2), .ANGLE_W(A2)) if1 ();

    cordic_iter_engine #(.WIDTH(W1), .ANGLE_W(A1), .ITER(I1)) dut (
        .clk(clk), .rst_n(rst_n), .io(if0)
    );

    cordic_iter_engine #(.WIDTH(W2), .ANGLE_W(A2), .ITER(I2)) dut_small (
        .clk(clk), .rst_n(rst_n), .io(if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint act, input longint exp,
                         input longint tol = 0);
        n_tests++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", tag, act, exp, tol);
        end
    endtask

    // Present one operand on the default instance and wait for its result.
    task automatic run_op(input string tag, input logic m, input longint x,
                          input longint y, input longint z);
        int lat;
        check({tag, "_in_ready"}, longint'(if0.in_ready), 1);
        if0.mode     = m;
        if0.x_in     = W1'(x);
        if0.y_in     = W1'(y);
        if0.z_in     = A1'(z);
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!if0.out_valid && lat < 100);
        check({tag, "_latency"}, longint'(lat), longint'(I1));
    endtask

    initial begin
        int lat;
        rst_n         = 1'b0;
        if0.in_valid  = 1'b0; if0.mode = 1'b0; if0.out_ready = 1'b1;
        if0.x_in      = '0;   if0.y_in = '0;   if0.z_in = '0;
        if1.in_valid  = 1'b0; if1.mode = 1'b0; if1.out_ready = 1'b1;
        if1.x_in      = '0;   if1.y_in = '0;   if1.z_in = '0;

        @(posedge clk); #1;
        check("rst_in_ready",  longint'(if0.in_ready), 1);
        check("rst_out_valid", longint'(if0.out_valid), 0);
        check("rst_x_out",     longint'(if0.x_out), 0);
        check("rst_z_out",     longint'(if0.z_out), 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Rotation by +pi/4 of (2^20/K, 0).
        run_op("rot", 1'b0, 636751, 0, 524288);
        check("rot_x", longint'(if0.x_out), 741455, 32);
        check("rot_y", longint'(if0.y_out), 741455, 32);
        check("rot_z", longint'(if0.z_out), 0, 32);
        @(posedge clk); #1;
        check("rot_release_valid", longint'(if0.out_valid), 0);
        check("rot_release_ready", longint'(if0.in_ready), 1);

        // Vectoring of (300000, 400000): magnitude 500000*K, angle atan2(4,3).
        run_op("vec", 1'b1, 300000, 400000, 0);
        check("vec_x", longint'(if0.x_out), 823380, 32);
        check("vec_y", longint'(if0.y_out), 0, 32);
        check("vec_z", longint'(if0.z_out), 619015, 32);
        @(posedge clk); #1;

        // Backpressure, with operand pulses while busy that must be ignored.
        if0.out_ready = 1'b0;
        if0.mode = 1'b0; if0.x_in = W1'(636751); if0.y_in = '0; if0.z_in = A1'(524288);
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.mode = 1'b1; if0.x_in = W1'(1000); if0.y_in = W1'(-50000); if0.z_in = A1'(12345);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 3) if0.in_valid = 1'b0;
            if (!if0.out_valid) check("bp_run_in_ready", longint'(if0.in_ready), 0);
        end while (!if0.out_valid && lat < 100);
        check("bp_latency", longint'(lat), longint'(I1));
        for (int k = 0; k < 10; k++) begin
            if0.in_valid = k[0];
            check("bp_out_valid", longint'(if0.out_valid), 1);
            check("bp_in_ready",  longint'(if0.in_ready), 0);
            check("bp_x_hold",    longint'(if0.x_out), 741455, 32);
            check("bp_y_hold",    longint'(if0.y_out), 741455, 32);
            @(posedge clk); #1;
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_valid_fall", longint'(if0.out_valid), 0);
        check("bp_ready_rise", longint'(if0.in_ready), 1);
        check("bp_idle_x_hold", longint'(if0.x_out), 741455, 32);

        // Abort mid-RUN with an asynchronous reset, then run a fresh operand.
        if0.mode = 1'b1; if0.x_in = W1'(300000); if0.y_in = W1'(400000); if0.z_in = '0;
        if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_in_ready",  longint'(if0.in_ready), 1);
        check("abort_out_valid", longint'(if0.out_valid), 0);
        check("abort_x_out",     longint'(if0.x_out), 0);
        check("abort_y_out",     longint'(if0.y_out), 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("neg", 1'b0, 636751, 0, -524288);
        check("neg_x", longint'(if0.x_out), 741455, 32);
        check("neg_y", longint'(if0.y_out), -741455, 32);
        check("neg_z", longint'(if0.z_out), 0, 32);
        @(posedge clk); #1;

        // 16-bit / 12-iteration instance: rotation by pi/4 of (2^15/K, 0).
        check("sw_in_ready", longint'(if1.in_ready), 1);
        if1.mode = 1'b0; if1.x_in = W2'(19898); if1.y_in = '0; if1.z_in = A2'(8192);
        if1.in_valid = 1'b1;
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!if1.out_valid && lat < 100);
        check("sw_latency", longint'(lat), longint'(I2));
        check("sw_x", longint'(if1.x_out), 23170, 16);
        check("sw_y", longint'(if1.y_out), 23170, 16);
        @(posedge clk); #1;
        check("sw_release_ready", longint'(if1.in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
